// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns one byte/half/word request into one or two word-aligned
// memory transfers and merges split read data. Define MISALIGN_TRAP_EN to reject split accesses.
module lsu_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_word,
    output logic [1:0]        resp_rem,
    output logic [2:0]        resp_funct3,
    output logic              resp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
    localparam logic [1:0] S_ACC1 = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_SPLIT = 1'b1;
`else
    localparam bit TRAP_SPLIT = 1'b0;
`endif

    function automatic logic [63:0] lane_data(input logic [31:0] d, input logic [1:0] r);
        return {32'b0, d} << {r, 3'b000};
    endfunction

    function automatic logic [7:0] lane_strb(input logic [1:0] sz, input logic [1:0] r);
        logic [3:0] mask;
        case (sz)
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return {4'b0000, mask} << r;
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] hi, input logic [31:0] lo,
                                               input logic [1:0] r);
        logic [63:0] t;
        t = {hi, lo} >> {r, 3'b000};
        return t[31:0];
    endfunction

    logic [1:0]        state;
    logic              we_p0;
    logic [2:0]        f3_p0;
    logic [1:0]        rem_p0;
    logic              split_p0;
    logic [ADDR_W-1:0] base_p0;
    logic [63:0]       data_p0;
    logic [7:0]        strb_p0;
    logic [31:0]       lo_p1;
    logic [31:0]       word_p1;
    logic              err_p1;

    logic legal, split_req;

    always_comb begin
        legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                (!req_we && ((req_funct3 == 3'b100) || (req_funct3 == 3'b101)));
        split_req = ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    // Request capture, memory sequencing and response formation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            we_p0    <= 1'b0;
            f3_p0    <= 3'b000;
            rem_p0   <= 2'b00;
            split_p0 <= 1'b0;
            base_p0  <= '0;
            data_p0  <= '0;
            strb_p0  <= '0;
            lo_p1    <= '0;
            word_p1  <= '0;
            err_p1   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    we_p0    <= req_we;
                    f3_p0    <= req_funct3;
                    rem_p0   <= req_addr[1:0];
                    split_p0 <= split_req;
                    base_p0  <= {req_addr[ADDR_W-1:2], 2'b00};
                    data_p0  <= lane_data(req_wdata, req_addr[1:0]);
                    strb_p0  <= lane_strb(req_funct3[1:0], req_addr[1:0]);
                    word_p1  <= '0;
                    if (!legal || (split_req && TRAP_SPLIT)) begin
                        err_p1 <= 1'b1;
                        state  <= S_RESP;
                    end else begin
                        err_p1 <= 1'b0;
                        state  <= S_ACC0;
                    end
                end
                S_ACC0: if (mem_ready) begin
                    lo_p1 <= mem_rdata;
                    if (split_p0) begin
                        state <= S_ACC1;
                    end else begin
                        word_p1 <= we_p0 ? 32'b0 : mem_rdata;
                        state   <= S_RESP;
                    end
                end
                S_ACC1: if (mem_ready) begin
                    word_p1 <= we_p0 ? 32'b0 : merge_word(mem_rdata, lo_p1, rem_p0);
                    state   <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Transfer and response outputs decoded from the current state
    always_comb begin
        req_ready   = (state == S_IDLE);
        mem_valid   = (state == S_ACC0) || (state == S_ACC1);
        mem_we      = mem_valid && we_p0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = 4'b0000;
        if (state == S_ACC0) begin
            mem_addr  = base_p0;
            mem_wdata = data_p0[31:0];
            mem_wstrb = we_p0 ? strb_p0[3:0] : 4'b0000;
        end else if (state == S_ACC1) begin
            mem_addr  = base_p0 + ADDR_W'(4);
            mem_wdata = data_p0[63:32];
            mem_wstrb = we_p0 ? strb_p0[7:4] : 4'b0000;
        end
        resp_valid  = (state == S_RESP);
        resp_word   = resp_valid ? word_p1 : 32'b0;
        resp_rem    = (resp_valid && !split_p0) ? rem_p0 : 2'b00;
        resp_funct3 = resp_valid ? f3_p0 : 3'b000;
        resp_err    = resp_valid && err_p1;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-level reference model, per-cycle output compare, directed vectors.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_word;
    logic [1:0]  resp_rem;
    logic [2:0]  resp_funct3;
    logic        resp_err;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_word(resp_word), .resp_rem(resp_rem),
        .resp_funct3(resp_funct3), .resp_err(resp_err)
    );

    // Fixed memory image; unlisted words hold an address-derived pattern
    function automatic logic [31:0] rdword(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'hDEAD_BEEF;
            32'h0000_0200: return 32'h80AA_BBCC;
            32'h0000_0104: return 32'h3499_8877;
            32'h0000_0108: return 32'h6655_4412;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign mem_rdata = rdword(mem_addr);

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } xfer_t;

    typedef struct {
        logic [31:0] word;
        logic [1:0]  rem;
        logic        chk_rem;
        logic [2:0]  f3;
        logic        err;
    } resp_t;

    xfer_t exp_x[$];
    resp_t exp_r[$];
    int    exp_nx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_total = 0;
    logic mon_en = 1'b0;
    logic [31:0] obs_addr[256];
    logic [31:0] obs_wdata[256];
    logic [3:0]  obs_wstrb[256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: transfers and response derived byte by byte from the request
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd);
        int          size;
        logic        legal, split;
        resp_t       rs;
        xfer_t       x;
        logic [31:0] base, ba, w;
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                (!we && ((f3 == 3'b100) || (f3 == 3'b101)));
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        split = (int'(addr[1:0]) + size) > 4;
        rs.f3 = f3;
        rs.word = 32'h0;
        rs.rem = addr[1:0];
        rs.chk_rem = !we;
        rs.err = 1'b0;
        exp_nx = 0;
        if (!legal) begin
            rs.err = 1'b1;
            rs.chk_rem = 1'b0;
        end
`ifdef MISALIGN_TRAP_EN
        else if (split) begin
            rs.err = 1'b1;
            rs.chk_rem = 1'b0;
        end
`endif
        else begin
            exp_nx = split ? 2 : 1;
            base = addr & ~32'h3;
            for (int t = 0; t < exp_nx; t++) begin
                x.addr  = base + 32'(4 * t);
                x.we    = we;
                x.wdata = 32'h0;
                x.wstrb = 4'b0000;
                if (we) begin
                    for (int i = 0; i < size; i++) begin
                        ba = addr + 32'(i);
                        if ((ba & ~32'h3) == x.addr) begin
                            x.wstrb[ba[1:0]] = 1'b1;
                            x.wdata[8*int'(ba[1:0]) +: 8] = wd[8*i +: 8];
                        end
                    end
                end
                exp_x.push_back(x);
            end
            if (!we) begin
                if (!split) begin
                    rs.word = rdword(base);
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        ba = addr + 32'(i);
                        w  = rdword(ba & ~32'h3);
                        rs.word[8*i +: 8] = w[8*int'(ba[1:0]) +: 8];
                    end
                    rs.rem = 2'b00;
                end
            end
        end
        exp_r.push_back(rs);
    endfunction

    // Per-cycle compare against the model queues
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (mem_valid) begin
                if (exp_x.size() == 0) begin
                    chk("xfer_unexpected", 32'(mem_valid), 32'd0);
                end else begin
                    chk("mem_addr", mem_addr, exp_x[0].addr);
                    chk("mem_we", 32'(mem_we), 32'(exp_x[0].we));
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_x[0].wstrb));
                    if (exp_x[0].we) chk("mem_wdata", mem_wdata, exp_x[0].wdata);
                    if (mem_ready) begin
                        obs_addr[hs_total % 256]  = mem_addr;
                        obs_wdata[hs_total % 256] = mem_wdata;
                        obs_wstrb[hs_total % 256] = mem_wstrb;
                        hs_total++;
                        void'(exp_x.pop_front());
                    end
                end
            end
            if (resp_valid) begin
                if (exp_r.size() == 0) begin
                    chk("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    chk("resp_word", resp_word, exp_r[0].word);
                    chk("resp_funct3", 32'(resp_funct3), 32'(exp_r[0].f3));
                    chk("resp_err", 32'(resp_err), 32'(exp_r[0].err));
                    if (exp_r[0].chk_rem) chk("resp_rem", 32'(resp_rem), 32'(exp_r[0].rem));
                    void'(exp_r.pop_front());
                end
            end
        end
    end

    // Issue one request, serve it with 'waits' stall cycles per transfer
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int waits,
                           output logic [31:0] word, output logic [1:0] rem,
                           output logic err, output int lat);
        int   acc, wc, nx, base_hs;
        logic done;
        wc = 0;
        done = 1'b0;
        word = 32'h0;
        rem = 2'b00;
        err = 1'b0;
        lat = 0;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        model(we, f3, addr, wd);
        nx = exp_nx;
        base_hs = hs_total;
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 acc = cyc;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                word = resp_word;
                rem = resp_rem;
                err = resp_err;
                lat = cyc - acc + 1;
                done = 1'b1;
                mem_ready = 1'b0;
            end else if (mem_valid) begin
                chk("req_ready_busy", 32'(req_ready), 32'd0);
                if (wc < waits) begin
                    mem_ready = 1'b0;
                    wc++;
                end else begin
                    mem_ready = 1'b1;
                    wc = 0;
                end
            end else begin
                mem_ready = 1'b0;
            end
        end
        chk("resp_seen", 32'(done), 32'd1);
        // acceptance cycle counts as cycle N
        chk("latency", 32'(lat), 32'(1 + nx * (1 + waits)));
        chk("xfer_count", 32'(hs_total - base_hs), 32'(nx));
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid), 32'd0);
        chk("req_ready_after", 32'(req_ready), 32'd1);
    endtask

    logic [31:0] w;
    logic [1:0]  rm;
    logic        e;
    int          l;
    logic [31:0] ra, tgt;
    logic [2:0]  rf;
    logic        found;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_word", resp_word, 32'd0);
        chk("rst_resp_rem", 32'(resp_rem), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, w, rm, e, l);
        chk("lw_word", w, 32'hDEAD_BEEF);
        chk("lw_lat", 32'(l), 32'd2);
        chk("lw_addr", obs_addr[(hs_total - 1) % 256], 32'h0000_0100);
        chk("lw_wstrb", 32'(obs_wstrb[(hs_total - 1) % 256]), 32'd0);

        run_req(1'b0, 3'b100, 32'h0000_0203, 32'h0, 0, w, rm, e, l);
        chk("lbu_word", w, 32'h80AA_BBCC);
        chk("lbu_rem", 32'(rm), 32'd3);
        chk("lbu_lat", 32'(l), 32'd2);

        run_req(1'b0, 3'b001, 32'h0000_0107, 32'h0, 0, w, rm, e, l);
`ifdef MISALIGN_TRAP_EN
        chk("lh_split_err", 32'(e), 32'd1);
        chk("lh_split_lat", 32'(l), 32'd1);
`else
        chk("lh_split_half", 32'(w[15:0]), 32'h1234);
        chk("lh_split_word", w, 32'h5544_1234);
        chk("lh_split_rem", 32'(rm), 32'd0);
        chk("lh_split_lat", 32'(l), 32'd3);
`endif

        run_req(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 0, w, rm, e, l);
`ifdef MISALIGN_TRAP_EN
        chk("sw_wrap_err", 32'(e), 32'd1);
`else
        chk("sw_wrap_addr0", obs_addr[(hs_total - 2) % 256], 32'hFFFF_FFFC);
        chk("sw_wrap_wdata0", obs_wdata[(hs_total - 2) % 256], 32'hC3D4_0000);
        chk("sw_wrap_wstrb0", 32'(obs_wstrb[(hs_total - 2) % 256]), 32'hC);
        chk("sw_wrap_addr1", obs_addr[(hs_total - 1) % 256], 32'h0000_0000);
        chk("sw_wrap_wdata1", obs_wdata[(hs_total - 1) % 256], 32'h0000_A1B2);
        chk("sw_wrap_wstrb1", 32'(obs_wstrb[(hs_total - 1) % 256]), 32'h3);
`endif

        run_req(1'b1, 3'b000, 32'h0000_0010, 32'h0000_005A, 3, w, rm, e, l);
        chk("sb_wait_lat", 32'(l), 32'd5);
        chk("sb_wait_wstrb", 32'(obs_wstrb[(hs_total - 1) % 256]), 32'h1);
        chk("sb_wait_byte", obs_wdata[(hs_total - 1) % 256] & 32'hFF, 32'h5A);

        run_req(1'b0, 3'b111, 32'h0000_0100, 32'h0, 0, w, rm, e, l);
        chk("ill_err", 32'(e), 32'd1);
        chk("ill_word", w, 32'd0);
        chk("ill_lat", 32'(l), 32'd1);

        run_req(1'b0, 3'b101, 32'h0000_0102, 32'h0, 0, w, rm, e, l);
        chk("lhu_word", w, 32'hDEAD_BEEF);
        chk("lhu_rem", 32'(rm), 32'd2);

        run_req(1'b1, 3'b001, 32'h0000_0101, 32'h0000_BEEF, 1, w, rm, e, l);
        chk("sh_mid_wdata", obs_wdata[(hs_total - 1) % 256], 32'h00BE_EF00);
        chk("sh_mid_wstrb", 32'(obs_wstrb[(hs_total - 1) % 256]), 32'h6);
        chk("sh_mid_lat", 32'(l), 32'd3);

        run_req(1'b1, 3'b100, 32'h0000_0020, 32'h0000_0011, 0, w, rm, e, l);
        chk("st_unsigned_err", 32'(e), 32'd1);

        run_req(1'b0, 3'b010, 32'h0000_0201, 32'h0, 0, w, rm, e, l);
`ifdef MISALIGN_TRAP_EN
        chk("lw_split_err", 32'(e), 32'd1);
`else
        chk("lw_split_word", w, 32'h0480_AABB);
`endif

        run_req(1'b1, 3'b010, 32'h0000_0102, 32'h1122_3344, 2, w, rm, e, l);

        // Reset while the last transfer of a load is outstanding
`ifdef MISALIGN_TRAP_EN
        ra = 32'h0000_0100; rf = 3'b010; tgt = 32'h0000_0100;
`else
        ra = 32'h0000_0107; rf = 3'b001; tgt = 32'h0000_0108;
`endif
        @(negedge clk);
        model(1'b0, rf, ra, 32'h0);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = rf;
        req_addr = ra;
        mem_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_valid && mem_addr == tgt) found = 1'b1;
        end
        mem_ready = 1'b0;
        mon_en = 1'b0;
        chk("rst_mid_reached", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_hold_mem_valid", 32'(mem_valid), 32'd0);
        end
        exp_x.delete();
        exp_r.delete();
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, w, rm, e, l);
        chk("post_rst_lw_word", w, 32'hDEAD_BEEF);
        chk("post_rst_lw_err", 32'(e), 32'd0);

        repeat (2) @(negedge clk);
        chk("xfer_queue_drained", 32'(exp_x.size()), 32'd0);
        chk("resp_queue_drained", 32'(exp_r.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the execute stage and the word-wide data memory.
- Accepts one byte/half/word request and issues word-aligned memory transfers with a valid/ready handshake.
- Splits accesses that cross a word boundary into two transfers and merges the read data.
- Delivers a 32-bit word plus a byte offset to the load-extraction datapath, which sign/zero-extends it.

Parameters:
- ADDR_W, 32, address width; memory addresses are word-aligned (low 2 bits always 0).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline request
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu (store uses 000/001/010)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- mem_valid  out  1  memory transfer request
- mem_ready  in  1  transfer completes when mem_valid & mem_ready; read data is valid in that same cycle
- mem_we  out  1  write transfer
- mem_addr  out  ADDR_W  word-aligned address
- mem_wdata  out  32  lane-positioned write data
- mem_wstrb  out  4  byte enables; 0000 on reads
- mem_rdata  in  32  read data
- resp_valid  out  1  one-cycle completion pulse, loads and stores
- resp_word  out  32  load word for the extractor
- resp_rem  out  2  byte offset for the extractor
- resp_funct3  out  3  funct3 of the completed request
- resp_err  out  1  request rejected, no memory side effect

Behaviour:
- Reset (async, rst_n=0): state IDLE. mem_valid, resp_valid, resp_err, mem_we = 0. mem_wstrb = 0. resp_word, mem_addr, mem_wdata = 0. resp_rem = 0. req_ready = 1 after release.
- Reset mid-transfer: mem_valid drops immediately and the request is abandoned.
- Size from funct3[1:0]: 00 → 1 byte, 01 → 2, 10 → 4. Offset r = req_addr[1:0].
- Illegal funct3 (011, 110, 111; or 100/101 with req_we=1): no memory access. RESP with resp_err=1, resp_word=0.
- Misaligned (split): half with r=3, or word with r≠0.
- Acceptance: latch all request fields. Compute a 64-bit lane image:
  - data64 = req_wdata << 8r
  - strb8 = (size mask 0001/0011/1111) << r
  - Go to ACC0.
- ACC0: mem_addr = {addr[31:2],2'b00}, mem_wdata = data64[31:0], mem_wstrb = strb8[3:0] (writes). On handshake, capture rdata as lo. Go to ACC1 if split, else RESP.
- ACC1: mem_addr = ACC0 address + 4, wrapping modulo 2^ADDR_W (0xFFFFFFFC → 0x00000000). mem_wdata = data64[63:32], mem_wstrb = strb8[7:4]. On handshake capture hi and go to RESP.
- mem_valid is held, with addr/wdata/wstrb/we stable, until mem_ready. No timeout.
- RESP (one cycle): resp_valid=1, then IDLE.
  - Aligned load: resp_word = lo, resp_rem = r.
  - Split load: resp_word = ({hi,lo} >> 8r)[31:0], resp_rem = 0.
  - Stores: resp_word = 0.
- Latency: aligned, zero-wait: request accepted at cycle N, mem_valid at N+1, resp_valid at N+2. Split: resp_valid at N+3. Each memory wait state adds 1 cycle.
- req_valid while busy: ignored (req_ready=0). Back-to-back: next acceptance no earlier than the cycle after RESP.

Optional Feature:
- MISALIGN_TRAP_EN defined: split-class requests are not issued. Go directly to RESP with resp_err=1, resp_word=0, no memory transfer; ACC1 is unreachable.
- Undefined: split/merge as above; resp_err only for illegal funct3.

Test Plan:
- lw addr 0x100, mem_ready=1, rdata 0xDEADBEEF → mem_addr 0x100, wstrb 0000; resp_word 0xDEADBEEF, resp_rem 0, resp_valid 2 cycles after acceptance.
- lbu addr 0x203, rdata 0x80AABBCC → resp_word 0x80AABBCC, resp_rem 3, funct3 100, single transfer.
- lh addr 0x107: ACC0 0x104 rdata 0x34xxxxxx, ACC1 0x108 rdata 0xxxxxxx12 → resp_word[15:0] 0x1234, resp_rem 0, resp_valid 3 cycles after acceptance. With MISALIGN_TRAP_EN → resp_err=1, mem_valid never asserted.
- sw addr 0xFFFFFFFE, wdata 0xA1B2C3D4 → ACC0 addr 0xFFFFFFFC, wdata 0xC3D40000, wstrb 1100; ACC1 addr 0x00000000, wdata 0x0000A1B2, wstrb 0011.
- sb addr 0x10 with mem_ready low 3 cycles → mem_valid/addr/wdata 0x000000xx/wstrb 0001 stable throughout; req_ready=0; resp_valid 1 cycle after mem_ready.
- rst_n low during ACC1 of a split load → mem_valid=0 immediately, no resp_valid; after release a new lw completes normally. Funct3 111 → resp_err=1, no transfer.
